sha1_msg_sched: RTL and testbench
=================================

Name: sha1_msg_sched

Overview:
- Upstream feeder for the quad round unit: accepts 512-bit message blocks as 16 × 32-bit words and expands each into the 80-word SHA-1 message schedule W[0..79].
- Emits one word per clock on Din together with phase_advance.
- Free-running cadence of 4 phases × 20 words, so the downstream round unit stays phase-locked even when no block is available.
- Double-buffered: the next block loads while the current one streams, so back-to-back blocks have no bubbles.

Parameters:
- PHASE_LEN, 20, words per phase; phase_advance marks word index PHASE_LEN-2 of each phase.
- PHASES, 4, phases per block; block length is PHASE_LEN*PHASES = 80.
- IDLE_WORD, 32'h0, value driven on Din when no block is active.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_word  input  32  message word, big-endian word order, W[0] first
- in_valid  input  1  in_word valid
- in_ready  output  1  shadow buffer can accept a word
- Din  output  32  schedule word to the round unit
- phase_advance  output  1  high with words t where t mod PHASE_LEN == PHASE_LEN-2
- word_valid  output  1  Din belongs to a real block (low during idle blocks)
- block_start  output  1  high with W[0] of a real block

Behaviour:
- Slot counter cnt runs 0..79 continuously, wrapping 79→0; reset sets cnt=0.
- Outputs are registered: output cycle k+1 carries the word for cnt value k.
- Reset values: Din=IDLE_WORD, phase_advance=0, word_valid=0, block_start=0, in_ready=1, shadow count=0, active block invalid.
- Shadow buffer, 16 words:
  - A word is accepted when in_valid && in_ready and written at index scount; scount then increments.
  - in_ready = (scount < 16), computed from registered state only.
- Swap:
  - Occurs on a cycle with cnt==79, or on the first cycle after reset with cnt==0.
  - If scount==16: shadow moves to the active buffer, active becomes valid, scount→0.
  - Otherwise active becomes invalid (idle block).
  - in_ready is low on a swap cycle because scount==16, so no word is accepted that cycle. Loading resumes the next cycle.
- Expansion uses a 16-word sliding window w[0..15], w[15] newest.
  - t<16: emit active[t] and shift it into the window.
  - t≥16: emit rotl1(w[13]^w[8]^w[2]^w[0]) and shift it into the window.
- Idle block: Din=IDLE_WORD, word_valid=0, block_start=0. phase_advance keeps its cadence.
- phase_advance is asserted for t=18, 38, 58 and 78 regardless of word_valid.
- block_start = word_valid && t==0.
- Reset mid-block or mid-load: all buffered words are discarded and the cadence restarts at t=0.

Optional Feature:
- Macro MSG_SHA0_EN.
- When defined: adds input port sha0 (1 bit), sampled at each swap and held for the whole block. When the sampled value is 1, W[t≥16] = w[13]^w[8]^w[2]^w[0] with no rotate (SHA-0 schedule).
- When undefined: no sha0 port; the rotate is always applied (SHA-1 only).

Decomposition:
- Shared package sha_pkg holds:
  - typedef word_t (32-bit unsigned)
  - constants BLOCK_WORDS=16, SCHED_WORDS=80
  - function rotl1
- One natural sub-module, sha1_w_window: the 16-deep window register plus the XOR/rotate expander, with a shift enable and a load-vs-expand select.

Test Plan:
- Reset only, no input for 200 cycles → Din=0 and word_valid=0 throughout; phase_advance high exactly at t=18, 38, 58, 78 of each 80-cycle slot.
- Load "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) before the first swap:
  - next slot emits those 16 words, then W16=0xC2C4C700, W17=0, W18=0x00000030 with phase_advance=1.
  - block_start=1 with W0 only.
- Two blocks presented back-to-back with in_valid held high → second block's W0 follows the first block's W79 on the next cycle; in_ready low from the 16th accepted word until the swap cycle.
- Block only half-loaded (8 words) at a cnt==79 swap → that slot is idle (word_valid=0); after the remaining 8 words arrive, the following slot emits the block correctly.
- Assert reset at t=40 of an active block with the shadow full → after release: outputs at reset values, in_ready=1, the next slot is idle, and the cadence restarts with phase_advance at t=18.
- With MSG_SHA0_EN defined and sha0=1, "abc" block → W16=0x61626380 (no rotate); with sha0=0 → W16=0xC2C4C700.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA definitions for the message-schedule slice.
//   word_t      : 32-bit schedule / message word
//   BLOCK_WORDS : message words per 512-bit block (16)
//   SCHED_WORDS : schedule words per block (80)
//   rotl1       : rotate a word left by one bit
package sha_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned SCHED_WORDS = 80;

    function automatic word_t rotl1(input word_t x);
        return {x[30:0], x[31]};
    endfunction

endpackage

// File: rtl/sha1_w_window.sv
// 16-deep sliding window of recent schedule words plus the W[t] expander.
// win[15] is the newest word (W[t-1]), win[0] the oldest (W[t-16]).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   shift_en    : shift next_word into the window this cycle
//   load_sel    : 1 = next_word is load_word (t < 16), 0 = expanded word
//   load_word   : message word to pass through while loading
//   rotate_en   : 1 = SHA-1 rotate on expanded words, 0 = SHA-0 (no rotate)
//   next_word   : schedule word for the current slot (combinational)
module sha1_w_window
    import sha_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  shift_en,
    input  logic  load_sel,
    input  word_t load_word,
    input  logic  rotate_en,
    output word_t next_word
);

    word_t win [BLOCK_WORDS];
    word_t mix;

    // Taps 13/8/2/0 are W[t-3], W[t-8], W[t-14], W[t-16].
    always_comb begin
        mix = win[13] ^ win[8] ^ win[2] ^ win[0];
        if (load_sel) begin
            next_word = load_word;
        end else if (rotate_en) begin
            next_word = rotl1(mix);
        end else begin
            next_word = mix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                win[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[BLOCK_WORDS-1] <= next_word;
        end
    end

endmodule

// File: rtl/sha1_msg_sched.sv
// SHA-1 message-schedule feeder for the quad round unit.
// Accepts 16-word blocks into a shadow buffer and streams the 80-word
// schedule W[0..79] one word per clock on a free-running 80-slot cadence.
// The shadow buffer loads while the active block streams (double buffering).
// Optional build macro MSG_SHA0_EN adds the sha0 input (SHA-0 schedule, no rotate).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   sha0           : (MSG_SHA0_EN only) SHA-0 select, sampled at each swap
//   in_word        : message word, W[0] first
//   in_valid       : in_word valid
//   in_ready       : shadow buffer can accept a word
//   Din            : schedule word to the round unit (IDLE_WORD when idle)
//   phase_advance  : high with slots t where t mod PHASE_LEN == PHASE_LEN-2
//   word_valid     : Din belongs to a real block
//   block_start    : high with W[0] of a real block
module sha1_msg_sched
    import sha_pkg::*;
#(
    parameter int unsigned PHASE_LEN = 20,
    parameter int unsigned PHASES    = 4,
    parameter word_t       IDLE_WORD = 32'h0
) (
    input  logic  clk,
    input  logic  reset,
`ifdef MSG_SHA0_EN
    input  logic  sha0,
`endif
    input  word_t in_word,
    input  logic  in_valid,
    output logic  in_ready,
    output word_t Din,
    output logic  phase_advance,
    output logic  word_valid,
    output logic  block_start
);

    localparam int unsigned SLOTS = PHASE_LEN * PHASES;
    localparam int unsigned CW    = $clog2(SLOTS);
    localparam int unsigned PW    = $clog2(PHASE_LEN);
    localparam int unsigned AW    = $clog2(BLOCK_WORDS);
    localparam int unsigned SW    = $clog2(BLOCK_WORDS + 1);

    word_t         shadow [BLOCK_WORDS];
    word_t         active [BLOCK_WORDS];
    logic [CW-1:0] cnt;
    logic [PW-1:0] pcnt;
    logic [SW-1:0] scount;
    logic          active_valid;
    logic          first_q;

    logic          slot_last;
    logic          phase_last;
    logic          shadow_full;
    logic          swap;
    logic          accept;
    logic          win_load;
    logic          rotate_en;
    word_t         win_next;

    assign slot_last   = (cnt == CW'(SLOTS - 1));
    assign phase_last  = (pcnt == PW'(PHASE_LEN - 1));
    assign shadow_full = (scount == SW'(BLOCK_WORDS));
    assign in_ready    = (scount < SW'(BLOCK_WORDS));
    assign accept      = in_valid && in_ready;
    // first_q gives the post-reset swap at cnt==0; scount is 0 then, so it
    // always marks the first slot idle.
    assign swap        = slot_last || first_q;
    assign win_load    = (cnt < CW'(BLOCK_WORDS));

`ifdef MSG_SHA0_EN
    logic sha0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sha0_q <= 1'b0;
        end else if (swap) begin
            sha0_q <= sha0;
        end
    end

    assign rotate_en = !sha0_q;
`else
    assign rotate_en = 1'b1;
`endif

    sha1_w_window u_window (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (active_valid),
        .load_sel  (win_load),
        .load_word (active[cnt[AW-1:0]]),
        .rotate_en (rotate_en),
        .next_word (win_next)
    );

    // Word storage carries no reset; scount and active_valid qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow[scount[AW-1:0]] <= in_word;
        end
        if (swap && shadow_full) begin
            active <= shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            pcnt          <= '0;
            scount        <= '0;
            active_valid  <= 1'b0;
            first_q       <= 1'b1;
            Din           <= IDLE_WORD;
            phase_advance <= 1'b0;
            word_valid    <= 1'b0;
            block_start   <= 1'b0;
        end else begin
            first_q <= 1'b0;
            cnt     <= slot_last ? '0 : cnt + 1'b1;
            // SLOTS is a multiple of PHASE_LEN, so pcnt stays aligned with cnt.
            pcnt    <= phase_last ? '0 : pcnt + 1'b1;

            if (accept) begin
                scount <= scount + 1'b1;
            end
            // accept cannot coincide with a full-shadow swap (in_ready is low).
            if (swap) begin
                if (shadow_full) begin
                    active_valid <= 1'b1;
                    scount       <= '0;
                end else begin
                    active_valid <= 1'b0;
                end
            end

            Din           <= active_valid ? win_next : IDLE_WORD;
            word_valid    <= active_valid;
            block_start   <= active_valid && (cnt == '0);
            phase_advance <= (pcnt == PW'(PHASE_LEN - 2));
        end
    end

endmodule

// File: tb/tb_sha1_msg_sched.sv
module tb_sha1_msg_sched;
    import sha_pkg::*;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  in_valid = 1'b0;
    logic  sha0 = 1'b0;
    word_t in_word = '0;
    logic  in_ready;
    word_t Din;
    logic  phase_advance;
    logic  word_valid;
    logic  block_start;

    int    checks = 0;
    int    errors = 0;
    int    ocyc = 0;
    word_t exp_q[$];
    word_t got_w[80];

    localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    logic [511:0] blk_b;

    sha1_msg_sched dut (
        .clk           (clk),
        .reset         (reset),
`ifdef MSG_SHA0_EN
        .sha0          (sha0),
`endif
        .in_word       (in_word),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .Din           (Din),
        .phase_advance (phase_advance),
        .word_valid    (word_valid),
        .block_start   (block_start)
    );

    always #5 clk = ~clk;

    // ocyc == k after the k-th rising edge since reset release; output slot t = (k-1) mod 80.
    always @(posedge clk) ocyc <= reset ? 0 : ocyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pa_exp(input int t);
        return (t % 20) == 18;
    endfunction

    task automatic push_sched(input logic [511:0] blk, input bit no_rot);
        word_t w[80];
        word_t x;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = no_rot ? x : {x[30:0], x[31]};
        end
        for (int t = 0; t < 80; t++) exp_q.push_back(w[t]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_words(input logic [511:0] blk, input int first, input int n,
                              output int stalls);
        int i = first;
        int guard = 0;
        logic acc;
        stalls = 0;
        while (i < first + n && guard < 400) begin
            in_valid = 1'b1;
            in_word = blk[511-32*i -: 32];
            acc = in_ready;
            tick();
            if (acc) i++;
            else stalls++;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (i != first + n) begin
            errors++;
            $display("FAIL load_words: accepted %0d words, required %0d", i - first, n);
        end
    endtask

    task automatic check_idle(input int ncyc, input string name);
        int t;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            t = (ocyc - 1) % 80;
            checks++;
            if ({word_valid, block_start, phase_advance} !== {1'b0, 1'b0, pa_exp(t)} ||
                Din !== 32'h0) begin
                errors++;
                $display("FAIL %s t=%0d: vld/bs/pa/Din=%b%b%b/%h required 00%b/00000000",
                         name, t, word_valid, block_start, phase_advance, Din, pa_exp(t));
            end
        end
    endtask

    task automatic check_stream(input int nblk, input int start_cyc, input string name);
        int guard = 0;
        int t;
        word_t e;
        while (block_start !== 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        checks++;
        if (block_start !== 1'b1) begin
            errors++;
            $display("FAIL %s block_start: not seen, required at cycle %0d", name, start_cyc);
            return;
        end
        checks++;
        if (ocyc != start_cyc) begin
            errors++;
            $display("FAIL %s start: cycle %0d required %0d", name, ocyc, start_cyc);
        end
        for (int i = 0; i < nblk * 80; i++) begin
            t = i % 80;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            got_w[t] = Din;
            checks++;
            if (Din !== e) begin
                errors++;
                $display("FAIL %s W[%0d] blk%0d: Din=%h required %h", name, t, i / 80, Din, e);
            end
            checks++;
            if ({word_valid, block_start, phase_advance} !== {1'b1, t == 0, pa_exp(t)}) begin
                errors++;
                $display("FAIL %s flags t=%0d: vld/bs/pa=%b%b%b required 1%b%b", name, t,
                         word_valid, block_start, phase_advance, t == 0, pa_exp(t));
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({Din, word_valid, block_start, phase_advance, in_ready} !== {32'h0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_values: Din=%h vld=%b bs=%b pa=%b rdy=%b required 0 0 0 0 1",
                     Din, word_valid, block_start, phase_advance, in_ready);
        end
    endtask

    task automatic test_idle();
        do_reset();
        check_idle(200, "idle");
    endtask

    task automatic test_abc();
        int st;
        do_reset();
        push_sched(ABC, 1'b0);
        load_words(ABC, 0, 16, st);
        check_stream(1, 81, "abc");
        checks++;
        if (got_w[16] !== 32'hC2C4C700 || got_w[17] !== 32'h0 || got_w[18] !== 32'h30) begin
            errors++;
            $display("FAIL abc_w16_18: %h %h %h required c2c4c700 00000000 00000030",
                     got_w[16], got_w[17], got_w[18]);
        end
        // Nothing reloaded, so the following slot is idle.
        checks++;
        if (word_valid !== 1'b0 || Din !== 32'h0) begin
            errors++;
            $display("FAIL abc_after: vld=%b Din=%h required 0 00000000", word_valid, Din);
        end
    endtask

    task automatic test_back_to_back();
        int st_a;
        int st_b;
        do_reset();
        fork
            begin
                push_sched(ABC, 1'b0);
                load_words(ABC, 0, 16, st_a);
                push_sched(blk_b, 1'b0);
                load_words(blk_b, 0, 16, st_b);
            end
            check_stream(2, 81, "b2b");
        join
        // in_ready low after the 16th word (cycle 16) through the swap at cnt 79.
        checks++;
        if (st_b != 64) begin
            errors++;
            $display("FAIL b2b_ready_low: %0d stall cycles required 64", st_b);
        end
    endtask

    task automatic test_half_load();
        int st;
        do_reset();
        push_sched(blk_b, 1'b0);
        load_words(blk_b, 0, 8, st);
        check_idle(100 - ocyc, "half_idle0");
        load_words(blk_b, 8, 8, st);
        check_idle(160 - ocyc, "half_idle1");
        check_stream(1, 161, "half");
    endtask

    task automatic test_reset_mid();
        int st;
        do_reset();
        load_words(ABC, 0, 16, st);
        load_words(blk_b, 0, 16, st);
        while (ocyc < 121) tick();
        checks++;
        if (word_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre: vld=%b rdy=%b required 1 0", word_valid, in_ready);
        end
        do_reset();
        checks++;
        if ({Din, word_valid, block_start, phase_advance, in_ready} !== {32'h0, 4'b0001}) begin
            errors++;
            $display("FAIL mid_reset_values: Din=%h vld=%b bs=%b pa=%b rdy=%b required 0 0 0 0 1",
                     Din, word_valid, block_start, phase_advance, in_ready);
        end
        check_idle(160, "mid_after");
    endtask

`ifdef MSG_SHA0_EN
    task automatic test_sha0();
        int st;
        do_reset();
        sha0 = 1'b1;
        push_sched(ABC, 1'b1);
        load_words(ABC, 0, 16, st);
        check_stream(1, 81, "sha0");
        checks++;
        if (got_w[16] !== 32'h61626380) begin
            errors++;
            $display("FAIL sha0_w16: %h required 61626380", got_w[16]);
        end
        do_reset();
        sha0 = 1'b0;
        push_sched(ABC, 1'b0);
        load_words(ABC, 0, 16, st);
        check_stream(1, 81, "sha1");
        checks++;
        if (got_w[16] !== 32'hC2C4C700) begin
            errors++;
            $display("FAIL sha1_w16: %h required c2c4c700", got_w[16]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = $urandom();
        test_reset();
        test_idle();
        test_abc();
        test_back_to_back();
        test_half_load();
        test_reset_mid();
`ifdef MSG_SHA0_EN
        test_sha0();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
